led_pattern_gen: RTL and testbench

//  Parametrised N-LED pattern sequencer for the board LED bank. Four run-time modes:

---
 rtl/led_pkg.sv | 25 ++
 rtl/led_pattern_gen_if.sv | 26 ++
 rtl/led_tick_gen.sv | 46 ++++
 rtl/led_pattern_gen.sv | 100 ++++++++++
 tb/tb_led_pattern_gen.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_pkg.sv
// Shared types and helpers for the LED pattern sequencer: mode encodings,
// bounce direction and a constant-width helper for the tick prescaler.
package led_pkg;

   typedef enum logic [1:0] {
      MODE_ROT_L  = 2'd0,
      MODE_ROT_R  = 2'd1,
      MODE_SPLIT  = 2'd2,
      MODE_BOUNCE = 2'd3
   } mode_e;

   typedef enum logic {
      DIR_LEFT  = 1'b0,
      DIR_RIGHT = 1'b1
   } dir_e;

   // Bits needed to hold 0..value-1; never less than one.
   function automatic int clog2(input int value);
      int bits;
      bits = 0;
      for (int v = value - 1; v > 0; v = v >> 1) bits++;
      return (bits < 1) ? 1 : bits;
   endfunction

endpackage

// File: rtl/led_pattern_gen_if.sv
// Control/status bundle of the LED pattern sequencer. The dim input exists
// only when LED_PWM_DIM_EN is defined.
interface led_pattern_gen_if #(
   parameter int N_LED = 8
);
   logic             en;
   logic [1:0]       mode;
   logic [1:0]       speed;
   logic             load;
   logic [N_LED-1:0] pattern_init;
   logic [N_LED-1:0] led;
   logic             step_o;
`ifdef LED_PWM_DIM_EN
   logic [3:0]       dim;

   modport master (output en, mode, speed, load, pattern_init, dim,
                   input  led, step_o);
   modport slave  (input  en, mode, speed, load, pattern_init, dim,
                   output led, step_o);
`else
   modport master (output en, mode, speed, load, pattern_init,
                   input  led, step_o);
   modport slave  (input  en, mode, speed, load, pattern_init,
                   output led, step_o);
`endif
endinterface

// File: rtl/led_tick_gen.sv
// Base-tick prescaler plus speed sub-divider; step_en is high for the one
// enabled cycle whose clock edge should advance the pattern.
module led_tick_gen
   import led_pkg::*;
#(
   parameter int TICK_DIV = 2_500_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       clr,
   input  logic [1:0] speed,
   output logic       step_en
);

   localparam int              CW      = clog2(TICK_DIV);
   localparam logic [CW-1:0]   CNT_MAX = CW'(TICK_DIV - 1);

   logic [CW-1:0] r_cnt;
   logic [2:0]    r_sub;
   logic          w_tick;
   logic [2:0]    w_sub_lim;

   assign w_tick    = en && (r_cnt == CNT_MAX);
   assign w_sub_lim = 3'((4'd1 << speed) - 4'd1);
   // >= rather than == so lowering speed mid-interval steps on the next tick.
   assign step_en   = w_tick && (r_sub >= w_sub_lim);

   // NOTE: state registers use non-blocking assignment so every flop samples
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_sub <= '0;
      end else if (clr) begin
         r_cnt <= '0;
         r_sub <= '0;
      end else if (w_tick) begin
         r_cnt <= '0;
         r_sub <= step_en ? 3'd0 : r_sub + 3'd1;
      end else if (en) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/led_pattern_gen.sv
// N-LED pattern sequencer: rotate-left/right, split-outward and bounce modes.
// Optional PWM dimming is compiled in with `define LED_PWM_DIM_EN.
module led_pattern_gen
   import led_pkg::*;
#(
   parameter int               N_LED      = 8,
   parameter int               TICK_DIV   = 2_500_000,
   parameter logic [N_LED-1:0] RESET_PAT  = N_LED'(8'b0001_1000),
   parameter bit               ACTIVE_LOW = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   led_pattern_gen_if.slave  bus
);

   localparam int H = N_LED / 2;

   logic [N_LED-1:0] r_pat;
   dir_e             r_dir;
   logic             r_step;
   logic             w_step_en;
   logic [N_LED-1:0] w_next_pat;
   dir_e             w_next_dir;
   logic [N_LED-1:0] w_lit;

   led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (bus.en),
      .clr     (bus.load),
      .speed   (bus.speed),
      .step_en (w_step_en)
   );

   // NOTE: defaults first so every path assigns both outputs and no latch forms.
   always_comb begin
      w_next_pat = r_pat;
      w_next_dir = r_dir;
      case (mode_e'(bus.mode))
         MODE_ROT_L: w_next_pat = {r_pat[N_LED-2:0], r_pat[N_LED-1]};
         MODE_ROT_R: w_next_pat = {r_pat[0], r_pat[N_LED-1:1]};
         MODE_SPLIT: w_next_pat = {r_pat[N_LED-2:H], r_pat[N_LED-1],
                                   r_pat[0], r_pat[H-1:1]};
         MODE_BOUNCE: begin
            // Non-circular: the bit reaching an edge turns the run around.
            if (r_dir == DIR_LEFT) begin
               if (r_pat[N_LED-1]) begin
                  w_next_dir = DIR_RIGHT;
                  w_next_pat = r_pat >> 1;
               end else begin
                  w_next_pat = r_pat << 1;
               end
            end else begin
               if (r_pat[0]) begin
                  w_next_dir = DIR_LEFT;
                  w_next_pat = r_pat << 1;
               end else begin
                  w_next_pat = r_pat >> 1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pat  <= RESET_PAT;
         r_dir  <= DIR_LEFT;
         r_step <= 1'b0;
      end else if (bus.load) begin
         r_pat  <= bus.pattern_init;
         r_dir  <= DIR_LEFT;
         r_step <= 1'b0;
      end else begin
         r_step <= w_step_en;
         if (w_step_en) begin
            r_pat <= w_next_pat;
            r_dir <= w_next_dir;
         end
      end
   end

`ifdef LED_PWM_DIM_EN
   logic [3:0] r_pwm_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_pwm_cnt <= 4'd0;
      else        r_pwm_cnt <= r_pwm_cnt + 4'd1;
   end

   assign w_lit = r_pat & {N_LED{r_pwm_cnt < bus.dim}};
`else
   assign w_lit = r_pat;
`endif

   assign bus.led    = w_lit ^ {N_LED{ACTIVE_LOW}};
   assign bus.step_o = r_step;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: table of step vectors with a scoreboard of
// expected patterns/intervals, plus reset, pause, load and speed sequences.
module tb_led_pattern_gen;
   import led_pkg::*;

   localparam int N  = 8;
   localparam int TD = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   led_pattern_gen_if #(.N_LED(N)) bus ();

   led_pattern_gen #(
      .N_LED(N), .TICK_DIV(TD), .RESET_PAT(8'h18), .ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

`ifdef LED_PWM_DIM_EN
   led_pattern_gen_if #(.N_LED(N)) bus2 ();

   led_pattern_gen #(
      .N_LED(N), .TICK_DIV(TD), .RESET_PAT(8'h18), .ACTIVE_LOW(1'b0)
   ) dut2 (
      .clk(clk), .rst_n(rst_n), .bus(bus2)
   );

   logic [3:0] tb_pwm;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) tb_pwm <= 4'd0;
      else        tb_pwm <= tb_pwm + 4'd1;
   end
`endif

   typedef struct {
      mode_e      mode;
      logic [1:0] speed;
      bit         do_load;
      logic [7:0] init;
      logic [7:0] exp_pat;
      int         exp_gap;
   } vec_t;

   typedef struct {
      logic [7:0] pat;
      int         gap;
   } exp_t;

   vec_t vecs [0:26];
   exp_t sb [$];
   int   n_vec  = 0;
   int   n_miss = 0;

   function automatic vec_t mk(input mode_e m, input logic [1:0] s, input bit ld,
                               input logic [7:0] init, input logic [7:0] pat,
                               input int gap);
      vec_t v;
      v.mode = m; v.speed = s; v.do_load = ld; v.init = init;
      v.exp_pat = pat; v.exp_gap = gap;
      return v;
   endfunction

   // Expected pin drive for a logical pattern on the active-low instance.
   function automatic logic [7:0] exp_led(input logic [7:0] p);
`ifdef LED_PWM_DIM_EN
      return (p & {8{tb_pwm < bus.dim}}) ^ 8'hFF;
`else
      return p ^ 8'hFF;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_step(input int budget, output int waited, output bit seen);
      waited = 0;
      seen   = 1'b0;
      while (!seen && waited < budget) begin
         @(negedge clk);
         waited++;
         if (bus.step_o) seen = 1'b1;
      end
   endtask

   task automatic push_exp(input logic [7:0] pat, input int gap);
      exp_t e;
      e.pat = pat;
      e.gap = gap;
      sb.push_back(e);
   endtask

   // Wait for the next step, pop the scoreboard and compare; base adds
   // cycles already spent in the interval before this call.
   task automatic expect_step(input string name, input int base);
      int   waited;
      bit   seen;
      exp_t e;
      wait_step(64, waited, seen);
      e = sb.pop_front();
      check({name, "_seen"}, 32'(seen), 32'd1);
      if (seen) begin
         check({name, "_led"}, 32'(bus.led), 32'(exp_led(e.pat)));
         check({name, "_gap"}, 32'(base + waited), 32'(e.gap));
      end
   endtask

   task automatic apply(input int i);
      bus.mode  = vecs[i].mode;
      bus.speed = vecs[i].speed;
      if (vecs[i].do_load) begin
         bus.pattern_init = vecs[i].init;
         bus.load         = 1'b1;
         @(negedge clk);
         bus.load = 1'b0;
         check($sformatf("vec%0d_load_led", i), 32'(bus.led),
               32'(exp_led(vecs[i].init)));
         check($sformatf("vec%0d_load_step", i), 32'(bus.step_o), 32'd0);
      end
      push_exp(vecs[i].exp_pat, vecs[i].exp_gap);
      expect_step($sformatf("vec%0d", i), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, want finish before 200us");
      $fatal(1, "watchdog");
   end

   initial begin
      int  stray;
      logic [7:0] bounce_pat;

      vecs[0] = mk(MODE_ROT_L, 2'd0, 1'b0, 8'h00, 8'h30, 4);
      vecs[1] = mk(MODE_ROT_L, 2'd0, 1'b0, 8'h00, 8'h60, 4);
      vecs[2] = mk(MODE_ROT_L, 2'd0, 1'b0, 8'h00, 8'hC0, 4);
      vecs[3] = mk(MODE_ROT_L, 2'd0, 1'b0, 8'h00, 8'h81, 4);
      vecs[4] = mk(MODE_SPLIT, 2'd0, 1'b0, 8'h00, 8'h24, 4);
      vecs[5] = mk(MODE_SPLIT, 2'd0, 1'b0, 8'h00, 8'h42, 4);
      vecs[6] = mk(MODE_SPLIT, 2'd0, 1'b0, 8'h00, 8'h81, 4);
      vecs[7] = mk(MODE_SPLIT, 2'd0, 1'b0, 8'h00, 8'h18, 4);
      vecs[8] = mk(MODE_BOUNCE, 2'd0, 1'b1, 8'h01, 8'h02, 4);
      bounce_pat = 8'h02;
      for (int k = 9; k <= 14; k++) begin
         bounce_pat = bounce_pat << 1;
         vecs[k] = mk(MODE_BOUNCE, 2'd0, 1'b0, 8'h00, bounce_pat, 4);
      end
      for (int k = 15; k <= 21; k++) begin
         bounce_pat = bounce_pat >> 1;
         vecs[k] = mk(MODE_BOUNCE, 2'd0, 1'b0, 8'h00, bounce_pat, 4);
      end
      vecs[22] = mk(MODE_BOUNCE, 2'd0, 1'b0, 8'h00, 8'h02, 4);
      vecs[23] = mk(MODE_ROT_R, 2'd0, 1'b1, 8'hFF, 8'hFF, 4);
      vecs[24] = mk(MODE_ROT_R, 2'd0, 1'b1, 8'h81, 8'hC0, 4);
      vecs[25] = mk(MODE_ROT_L, 2'd2, 1'b0, 8'h00, 8'h81, 16);
      vecs[26] = mk(MODE_ROT_L, 2'd2, 1'b0, 8'h00, 8'h03, 16);

      bus.en = 1'b1; bus.mode = MODE_ROT_L; bus.speed = 2'd0;
      bus.load = 1'b0; bus.pattern_init = 8'h00;
`ifdef LED_PWM_DIM_EN
      bus.dim = 4'd15;
      bus2.en = 1'b0; bus2.mode = MODE_ROT_L; bus2.speed = 2'd0;
      bus2.load = 1'b0; bus2.pattern_init = 8'h00; bus2.dim = 4'd4;
`endif

      repeat (2) @(negedge clk);
      check("reset_led", 32'(bus.led), 32'(exp_led(8'h18)));
      check("reset_step", 32'(bus.step_o), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i <= 3; i++) apply(i);

      // Reset while step_o is high and a fresh pattern is showing.
      rst_n = 1'b0;
      #1;
      check("midstep_reset_led", 32'(bus.led), 32'(exp_led(8'h18)));
      check("midstep_reset_step", 32'(bus.step_o), 32'd0);
      bus.en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         check($sformatf("hold%0d_led", c), 32'(bus.led), 32'(exp_led(8'h18)));
         check($sformatf("hold%0d_step", c), 32'(bus.step_o), 32'd0);
      end
      bus.en = 1'b1;

      for (int i = 4; i <= 26; i++) apply(i);

      // Pause 10 cycles mid-interval at speed 2: the step slips by 10.
      stray = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.step_o) stray++;
      end
      bus.en = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (bus.step_o) stray++;
      end
      bus.en = 1'b1;
      check("pause_no_step", 32'(stray), 32'd0);
      push_exp(8'h06, 26);
      expect_step("pause_resume", 16);

      // Load lands on the edge that would have stepped.
      stray = 0;
      repeat (15) begin
         @(negedge clk);
         if (bus.step_o) stray++;
      end
      check("preload_no_step", 32'(stray), 32'd0);
      bus.pattern_init = 8'hA5;
      bus.load = 1'b1;
      @(negedge clk);
      bus.load = 1'b0;
      check("load_on_step_led", 32'(bus.led), 32'(exp_led(8'hA5)));
      check("load_on_step_step", 32'(bus.step_o), 32'd0);
      push_exp(8'h4B, 16);
      expect_step("after_load", 0);

      // Dropping speed after two ticks of a speed-2 interval steps on tick 3.
      repeat (9) @(negedge clk);
      bus.speed = 2'd0;
      push_exp(8'h96, 12);
      expect_step("speed_drop", 9);

`ifdef LED_PWM_DIM_EN
      begin
         int on_cnt;
         int off_cnt;
         bus2.pattern_init = 8'hFF;
         bus2.load = 1'b1;
         @(negedge clk);
         bus2.load = 1'b0;
         on_cnt = 0; off_cnt = 0;
         repeat (16) begin
            @(negedge clk);
            if (bus2.led == 8'hFF) on_cnt++;
            if (bus2.led == 8'h00) off_cnt++;
         end
         check("pwm_dim4_on", 32'(on_cnt), 32'd4);
         check("pwm_dim4_off", 32'(off_cnt), 32'd12);
         bus2.dim = 4'd0;
         off_cnt = 0;
         repeat (16) begin
            @(negedge clk);
            if (bus2.led == 8'h00) off_cnt++;
         end
         check("pwm_dim0_off", 32'(off_cnt), 32'd16);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
